// File: rtl/arbiter_client_2ch.sv
// Two-channel client of a round-robin arbiter. Each channel has a FIFO that
// requests a grant while non-empty; a legal grant pops one word, which is
// presented on out_* one cycle later. Protocol violations set a sticky error.
// Ports: clk, rst (sync, active-low), in_valid/in_data0/in_data1/in_ready
// (per-channel push), requests/grants (arbiter side), out_valid/out_data/
// out_id (granted word), error (sticky grant-protocol violation).
module arbiter_client_2ch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  output logic [1:0]       in_ready,
  output logic [1:0]       requests,
  input  logic [1:0]       grants,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  ptr_t             wptr_q [2];
  ptr_t             wptr_d [2];
  ptr_t             rptr_q [2];
  ptr_t             rptr_d [2];
  cnt_t             cnt_q  [2];
  cnt_t             cnt_d  [2];

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic             oid_q, oid_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] din [2];
  logic [1:0]       push;
  logic [1:0]       pop;
  logic             legal;
  logic             gid;

  assign din[0] = in_data0;
  assign din[1] = in_data1;

  // Flags come from registered counts only, so a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    in_ready = 2'b00;
    requests = 2'b00;
    for (int i = 0; i < 2; i++) begin
      in_ready[i] = (cnt_q[i] != FULL);
      requests[i] = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    gid   = grants[1];
    legal = ((grants == 2'b01) && requests[0]) ||
            ((grants == 2'b10) && requests[1]);
    pop   = legal ? grants : 2'b00;
    push  = in_valid & in_ready;

    for (int i = 0; i < 2; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (push[i]) wptr_d[i] = wptr_q[i] + ptr_t'(1);
      if (pop[i])  rptr_d[i] = rptr_q[i] + ptr_t'(1);
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + cnt_t'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - cnt_t'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    ov_d  = legal;
    od_d  = od_q;
    oid_d = oid_q;
    if (legal) begin
      od_d  = mem_q[gid][rptr_q[gid]];
      oid_d = gid;
    end
    err_d = err_q | ((grants != 2'b00) & ~legal);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ov_q  <= 1'b0;
      od_q  <= '0;
      oid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      ov_q  <= ov_d;
      od_q  <= od_d;
      oid_q <= oid_d;
      err_q <= err_d;
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst && push[i]) mem_q[i][wptr_q[i]] <= din[i];
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_id    = oid_q;
  assign error     = err_q;

endmodule

// File: tb/tb_arbiter_client_2ch.sv
// Bench for arbiter_client_2ch: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_arbiter_client_2ch;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [1:0]       in_ready;
  logic [1:0]       requests;
  logic [1:0]       grants;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  logic             error;

  arbiter_client_2ch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
    .in_ready(in_ready), .requests(requests), .grants(grants),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic             m_oid;
  logic             m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_req();
    return {q1.size() != 0, q0.size() != 0};
  endfunction

  function automatic logic [1:0] m_rdy();
    return {q1.size() != DEPTH, q0.size() != DEPTH};
  endfunction

  // Reference behaviour for one clock edge, from the rules of the block.
  task automatic model(input logic r, input logic [1:0] iv,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] g);
    logic [1:0] req;
    logic [1:0] rdy;
    logic       ok;
    if (!r) begin
      q0.delete(); q1.delete();
      m_ov = 0; m_od = '0; m_oid = 0; m_err = 0;
      return;
    end
    req = m_req();
    rdy = m_rdy();
    ok  = (g == 2'b01 && req[0]) || (g == 2'b10 && req[1]);
    m_ov = ok;
    if (ok) begin
      if (g == 2'b01) begin m_od = q0.pop_front(); m_oid = 0; end
      else            begin m_od = q1.pop_front(); m_oid = 1; end
    end else if (g != 2'b00) begin
      m_err = 1;
    end
    if (iv[0] && rdy[0]) q0.push_back(a);
    if (iv[1] && rdy[1]) q1.push_back(b);
  endtask

  task automatic compare_all();
    chk("in_ready",  in_ready,  m_rdy());
    chk("requests",  requests,  m_req());
    chk("out_valid", out_valid, m_ov);
    chk("out_data",  out_data,  m_od);
    chk("out_id",    out_id,    m_oid);
    chk("error",     error,     m_err);
  endtask

  // Called at a falling edge: drive, advance model, clock, then compare.
  task automatic step(input logic r, input logic [1:0] iv,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [1:0] g);
    rst = r; in_valid = iv; in_data0 = a; in_data1 = b; grants = g;
    model(r, iv, a, b, g);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1, 2'b00, '0, '0, 2'b00);
  endtask

  initial begin
    rst = 0; in_valid = 0; in_data0 = 0; in_data1 = 0; grants = 0;
    m_ov = 0; m_od = 0; m_oid = 0; m_err = 0;
    @(negedge clk);
    step(0, 2'b11, 8'h12, 8'h34, 2'b11);
    step(0, 2'b00, '0, '0, 2'b00);
    chk("rst_requests", requests, 2'b00);
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_error", error, 0);

    // single word through channel 0
    step(1, 2'b01, 8'hA5, '0, 2'b00);
    chk("s1_requests", requests, 2'b01);
    step(1, 2'b00, '0, '0, 2'b01);
    chk("s1_out_valid", out_valid, 1);
    chk("s1_out_data", out_data, 8'hA5);
    chk("s1_out_id", out_id, 0);
    chk("s1_requests_after", requests, 2'b00);
    idle();
    chk("s1_valid_drop", out_valid, 0);
    chk("s1_data_hold", out_data, 8'hA5);

    // channel 1 fill / overflow / drain, three times for wrap
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 5; k++) begin
        step(1, 2'b10, '0, 8'(8'h10 * (rep + 1) + k), 2'b00);
        if (k == 3) chk("s2_full", in_ready[1], 0);
      end
      for (int k = 0; k < 4; k++) begin
        step(1, 2'b00, '0, '0, 2'b10);
        chk("s2_order", out_data, 8'(8'h10 * (rep + 1) + k));
        chk("s2_id", out_id, 1);
      end
      chk("s2_empty", requests, 2'b00);
    end

    // alternating grants
    step(1, 2'b11, 8'h31, 8'h41, 2'b00);
    step(1, 2'b11, 8'h32, 8'h42, 2'b00);
    step(1, 2'b00, '0, '0, 2'b01);
    chk("s3_d0", {out_id, out_data}, {1'b0, 8'h31});
    step(1, 2'b00, '0, '0, 2'b10);
    chk("s3_d1", {out_id, out_data}, {1'b1, 8'h41});
    step(1, 2'b00, '0, '0, 2'b01);
    chk("s3_d2", {out_id, out_data}, {1'b0, 8'h32});
    step(1, 2'b00, '0, '0, 2'b10);
    chk("s3_d3", {out_id, out_data}, {1'b1, 8'h42});
    chk("s3_error", error, 0);

    // both grant bits at once
    step(1, 2'b11, 8'h55, 8'h66, 2'b00);
    step(1, 2'b00, '0, '0, 2'b11);
    chk("s4_no_valid", out_valid, 0);
    chk("s4_error", error, 1);
    chk("s4_counts", requests, 2'b11);
    idle(); idle();
    chk("s4_sticky", error, 1);
    step(0, 2'b00, '0, '0, 2'b00);
    chk("s4_cleared", error, 0);

    // grant to empty channel with simultaneous push
    step(1, 2'b01, 8'h77, '0, 2'b01);
    chk("s5_error", error, 1);
    chk("s5_no_valid", out_valid, 0);
    chk("s5_kept", requests, 2'b01);
    step(1, 2'b00, '0, '0, 2'b01);
    chk("s5_data", out_data, 8'h77);
    step(0, 2'b00, '0, '0, 2'b00);

    // full channel: pop plus push in one cycle, push blocked
    for (int k = 0; k < 4; k++) step(1, 2'b01, 8'(8'h81 + k), '0, 2'b00);
    step(1, 2'b01, 8'h99, '0, 2'b01);
    chk("s6_pop", out_data, 8'h81);
    chk("s6_ready", in_ready[0], 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 2'b00, '0, '0, 2'b01);
      chk("s6_order", out_data, 8'(8'h82 + k));
    end
    chk("s6_dropped", requests, 2'b00);

    // reset mid-stream
    step(1, 2'b11, 8'h5A, 8'hC3, 2'b00);
    step(1, 2'b11, 8'h5B, 8'hC4, 2'b10);
    chk("s7_pre_id", out_id, 1);
    step(0, 2'b11, 8'hEE, 8'hEE, 2'b10);
    chk("s7_outs", {out_valid, out_data, out_id, error}, 11'h0);
    chk("s7_requests", requests, 2'b00);
    chk("s7_in_ready", in_ready, 2'b11);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned gr;
      logic [1:0]  g;
      gr = $urandom_range(0, 15);
      if (gr < 6)       g = 2'b00;
      else if (gr < 11) g = 2'b01;
      else if (gr < 15) g = 2'b10;
      else              g = 2'b11;
      step(($urandom_range(0, 99) != 0), 2'($urandom),
           8'($urandom), 8'($urandom), g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbiter_client_2ch.md
ARBITER_CLIENT_2CH -- requirements
Module: arbiter_client_2ch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning per-channel FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-005 SHALL have port in_valid  input  2  per-channel push request; bit i is channel i.
REQ-006 SHALL have port in_data0  input  WIDTH  channel 0 payload.
REQ-007 SHALL have port in_data1  input  WIDTH  channel 1 payload.
REQ-008 SHALL have port in_ready  output  2  per-channel FIFO not full.
REQ-009 SHALL have port requests  output  2  requests to the 2-request round-robin arbiter; bit i is channel i.
REQ-010 SHALL have port grants  input  2  grants from the arbiter; one-hot or zero expected.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse: the granted word is on out_data.
REQ-012 SHALL have port out_data  output  WIDTH  granted payload.
REQ-013 SHALL have port out_id  output  1  channel that supplied out_data.
REQ-014 SHALL have port error  output  1  sticky grant-protocol violation flag.

Function
REQ-015 SHALL contain one FIFO per channel: DEPTH entries, read/write pointers that wrap modulo DEPTH, and a count register 0..DEPTH.
REQ-016 SHALL drive in_ready[i] = (count_i != DEPTH), decoded from registered state only; no same-cycle pop-to-push pass-through.
REQ-017 SHALL push in_dataI into FIFO i on a cycle where in_valid[i] && in_ready[i]; in_valid while not ready is dropped with no state change.
REQ-018 SHALL drive requests[i] = (count_i != 0), decoded from registered state only; no combinational path from in_valid or grants.
REQ-019 SHALL treat a grant as legal when grants is 2'b01 or 2'b10 and the matching requests bit is 1.
REQ-020 SHALL, on a legal grant to channel i: pop the head of FIFO i, and in the next cycle assert out_valid=1, out_data=popped word, out_id=i (latency 1).
REQ-021 SHALL deassert out_valid in any cycle not following a legal grant; out_data and out_id SHALL hold their last values; there is no output backpressure.
REQ-022 SHALL treat grants=2'b11, or a grant bit whose requests bit is 0, as illegal: no pop, no out_valid, error set to 1 from the next cycle.
REQ-023 SHALL hold error at 1 until reset; grants=2'b00 is idle and never an error.
REQ-024 SHALL, on a legal grant and a push on the same channel in the same cycle, perform both; count unchanged; this is permitted when full (pop frees no slot that cycle, push still blocked by REQ-016).
REQ-025 SHALL keep a grant to an empty channel illegal, even if a push to that channel occurs in the same cycle.
REQ-026 SHALL preserve per-channel FIFO order across pointer wrap-around; channels are fully independent.

Reset
REQ-027 SHALL, when rst=0 at a rising edge, clear counts, pointers, out_valid, out_data, out_id and error to 0, regardless of operations in flight; pending FIFO contents are discarded.
REQ-028 SHALL, during and immediately after reset, present requests=2'b00 and in_ready=2'b11; pushes and grants in the reset cycle SHALL be ignored.

Verification
REQ-029 SHALL cover: push 0xA5 on ch0 -> requests=01 next cycle; grants=01 -> out_valid=1, out_data=0xA5, out_id=0 one cycle later; requests=00.
REQ-030 SHALL cover: push 4 words on ch1 -> in_ready[1]=0 and a 5th push dropped; 4 grants=10 -> words out in push order; repeat 3x to exercise wrap.
REQ-031 SHALL cover: both channels non-empty, grants alternate 01/10 -> out_id alternates 0,1,0,1 with matching data; error stays 0.
REQ-032 SHALL cover: grants=11 with both requesting -> no out_valid, counts unchanged, error=1 and held until rst=0.
REQ-033 SHALL cover: grants=01 while ch0 empty and a ch0 push in the same cycle -> error=1, pushed word retained (count_0=1).
REQ-034 SHALL cover: ch0 full, legal grant plus in_valid[0] in the same cycle -> push blocked, count_0=DEPTH-1; rst=0 mid-stream -> all outputs 0, requests=00, in_ready=11.
